// File: rtl/proc_dot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : proc_dot_sequencer
// Purpose  : Control/data master for a multiply-accumulate processor. Pops
//            operand pairs from FIFOs A and B, issues them one at a time,
//            holds retro low on the first element of a vector and high on the
//            rest so the processor accumulates, then pushes the final result
//            to the result FIFO.
// Ports    : clk, rst (async, active-high)
//            start            - begin one vector (ignored while busy)
//            a_empty/a_data/a_pop, b_empty/b_data/b_pop - operand FIFOs (FWFT)
//            A, B, enable, retro, out, done             - processor interface
//            res_full/res_push/res_data                 - result FIFO
//            busy, vec_done   - status
// Revision : 1.0 - initial release
// ============================================================================
module proc_dot_sequencer #(
  parameter int DW      = 16,
  parameter int VEC_LEN = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          a_empty,
  input  logic [DW-1:0] a_data,
  output logic          a_pop,
  input  logic          b_empty,
  input  logic [DW-1:0] b_data,
  output logic          b_pop,
  output logic [DW-1:0] A,
  output logic [DW-1:0] B,
  output logic          enable,
  output logic          retro,
  input  logic [DW-1:0] out,
  input  logic          done,
  input  logic          res_full,
  output logic          res_push,
  output logic [DW-1:0] res_data,
  output logic          busy,
  output logic          vec_done
);

  localparam int CW = $clog2(VEC_LEN + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_STORE = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] res_q, res_d;
  logic          vec_done_q, vec_done_d;
  logic          pop_w;
  logic          push_w;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    vec_done_d = 1'b0;
    pop_w      = 1'b0;
    push_w     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end
      end
      S_FETCH: begin
        // Both FIFOs must have data so the operand pair is popped atomically.
        if (!a_empty && !b_empty) begin
          a_d     = a_data;
          b_d     = b_data;
          pop_w   = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done) begin
          res_d   = out;
          cnt_d   = cnt_q + CW'(1);
          state_d = (cnt_q == CW'(VEC_LEN - 1)) ? S_STORE : S_FETCH;
        end
      end
      S_STORE: begin
        if (!res_full) begin
          push_w     = 1'b1;
          vec_done_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      vec_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      vec_done_q <= vec_done_d;
    end
  end

  // Strobes decode straight from the state register so that an asynchronous
  // reset clears them immediately.
  assign a_pop    = pop_w;
  assign b_pop    = pop_w;
  assign A        = a_q;
  assign B        = b_q;
  assign enable   = (state_q == S_ISSUE);
  assign retro    = ((state_q == S_ISSUE) || (state_q == S_WAIT)) && (cnt_q != '0);
  assign res_push = push_w;
  assign res_data = res_q;
  assign busy     = (state_q != S_IDLE);
  assign vec_done = vec_done_q;

endmodule
`default_nettype wire

// File: tb/tb_proc_dot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_proc_dot_sequencer
// Purpose  : Self-checking bench for proc_dot_sequencer (VEC_LEN=4 and 1),
//            with operand FIFO models, a MAC processor model and a result
//            scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_proc_dot_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- VEC_LEN = 4 instance ----------------
  logic        start, a_empty, b_empty, a_pop, b_pop, enable, retro, done;
  logic        res_full, res_push, busy, vec_done, force_done;
  logic [15:0] a_data, b_data, A, B, out, res_data;

  proc_dot_sequencer #(.DW(16), .VEC_LEN(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_empty(a_empty), .a_data(a_data), .a_pop(a_pop),
    .b_empty(b_empty), .b_data(b_data), .b_pop(b_pop),
    .A(A), .B(B), .enable(enable), .retro(retro), .out(out), .done(done),
    .res_full(res_full), .res_push(res_push), .res_data(res_data),
    .busy(busy), .vec_done(vec_done)
  );

  // ---------------- VEC_LEN = 1 instance ----------------
  logic        start1, a_pop1, b_pop1, enable1, retro1, done1, res_push1, busy1, vec_done1;
  logic [15:0] A1, B1, out1, res_data1;

  proc_dot_sequencer #(.DW(16), .VEC_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .a_empty(1'b0), .a_data(16'd9), .a_pop(a_pop1),
    .b_empty(1'b0), .b_data(16'd3), .b_pop(b_pop1),
    .A(A1), .B(B1), .enable(enable1), .retro(retro1), .out(out1), .done(done1),
    .res_full(1'b0), .res_push(res_push1), .res_data(res_data1),
    .busy(busy1), .vec_done(vec_done1)
  );

  // ---------------- FIFO models (first-word-fall-through) ----------------
  logic [15:0] mem_a [0:63];
  logic [15:0] mem_b [0:63];
  logic [5:0]  wa, wb, ra, rb;

  assign a_empty = (ra == wa);
  assign b_empty = (rb == wb);
  assign a_data  = mem_a[ra];
  assign b_data  = mem_b[rb];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ra <= wa;
      rb <= wb;
    end else begin
      if (a_pop) ra <= ra + 6'd1;
      if (b_pop) rb <= rb + 6'd1;
    end
  end

  // ---------------- processor models: out = A*B + (retro ? prev : 0) ----------------
  logic        done_r, done1_r;
  logic [15:0] p_out, p_out1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      done_r  <= 1'b0;
      p_out   <= 16'd0;
      done1_r <= 1'b0;
      p_out1  <= 16'd0;
    end else begin
      done_r  <= enable;
      done1_r <= enable1;
      if (enable)  p_out  <= A * B + (retro ? p_out : 16'd0);
      if (enable1) p_out1 <= A1 * B1 + (retro1 ? p_out1 : 16'd0);
    end
  end

  assign out   = p_out;
  assign done  = done_r | force_done;
  assign out1  = p_out1;
  assign done1 = done1_r;

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0][15:0] a;
    logic [3:0][15:0] b;
    logic [15:0]      exp;
  } vec_t;

  vec_t tbl [3];

  // ---------------- bookkeeping ----------------
  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_q[$];
  int          pops = 0, ens = 0, pushes = 0, pushes1 = 0;
  logic [15:0] rhist = '0;
  logic        last_en = 1'b0, prev_push = 1'b0, saw_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample everything on the falling edge, return 1ns after the
  // next rising edge so the caller can drive inputs.
  task automatic cyc();
    @(negedge clk);
    if (!busy) chk("idle_quiet", {59'd0, a_pop, b_pop, enable, res_push, retro}, 64'd0);
    if (a_pop || b_pop) begin
      chk("pop_pair", {63'd0, a_pop}, {63'd0, b_pop});
      pops++;
    end
    if (enable) begin
      ens++;
      rhist = {rhist[14:0], retro};
    end
    last_en = enable;
    if (res_push) begin
      pushes++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL push_expected: got push of %0h, expected none", res_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        checks--;
        chk("res_data", {48'd0, res_data}, {48'd0, e});
      end
    end
    if (vec_done || prev_push) chk("vec_done_pulse", {63'd0, vec_done}, {63'd0, prev_push});
    prev_push = res_push;
    if (vec_done) saw_done = 1'b1;
    if (enable1) chk("retro_len1", {63'd0, retro1}, 64'd0);
    if (res_push1) begin
      pushes1++;
      chk("res_data_len1", {48'd0, res_data1}, 64'd27);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input vec_t v);
    for (int i = 0; i < 4; i++) begin
      mem_a[wa] = v.a[i];
      wa = wa + 6'd1;
    end
  endtask

  task automatic load_b(input vec_t v);
    for (int i = 0; i < 4; i++) begin
      mem_b[wb] = v.b[i];
      wb = wb + 6'd1;
    end
  endtask

  task automatic wait_done(input int max);
    saw_done = 1'b0;
    for (int n = 0; n < max && !saw_done; n++) cyc();
    if (!saw_done) begin
      checks++;
      errors++;
      $display("FAIL vec_done_timeout: got none, expected within %0d cycles", max);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Full vector with pop/enable/retro/push accounting.
  task automatic run_vec(input vec_t v);
    int p0, e0, u0;
    p0 = pops; e0 = ens; u0 = pushes;
    load_a(v);
    load_b(v);
    exp_q.push_back(v.exp);
    pulse_start();
    wait_done(200);
    chk("pop_count", 64'(pops - p0), 64'd4);
    chk("enable_count", 64'(ens - e0), 64'd4);
    chk("retro_pattern", {60'd0, rhist[3:0]}, 64'b0111);
    chk("push_count", 64'(pushes - u0), 64'd1);
    chk("idle_after", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p0, e0, u0, n;
    tbl[0].a = {16'd4, 16'd3, 16'd2, 16'd1};
    tbl[0].b = {16'd8, 16'd7, 16'd6, 16'd5};
    tbl[0].exp = 16'd70;
    tbl[1].a = {16'd4000, 16'd3000, 16'd2000, 16'd1000};
    tbl[1].b = {16'd20, 16'd20, 16'd20, 16'd20};
    tbl[1].exp = 16'd3392;                  // 200000 mod 65536
    tbl[2].a = {16'd3, 16'd1, 16'd0, 16'd2};
    tbl[2].b = {16'd1, 16'd5, 16'd9, 16'd4};
    tbl[2].exp = 16'd16;

    rst = 1'b1; start = 1'b0; start1 = 1'b0; res_full = 1'b0; force_done = 1'b0;
    wa = '0; wb = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs",
        {15'd0, a_pop, b_pop, enable, retro, res_push, busy, vec_done, A, B, res_data},
        64'd0);
    rst = 1'b0;
    cyc();

    // Table-driven vectors
    for (int v = 0; v < 3; v++) run_vec(tbl[v]);

    // B empty for 5 cycles while A holds data
    p0 = pops; e0 = ens;
    load_a(tbl[0]);
    exp_q.push_back(tbl[0].exp);
    pulse_start();
    repeat (5) cyc();
    chk("no_pop_b_empty", 64'(pops - p0), 64'd0);
    chk("no_enable_b_empty", 64'(ens - e0), 64'd0);
    load_b(tbl[0]);
    cyc();
    chk("pop_on_fill", 64'(pops - p0), 64'd1);
    wait_done(200);
    chk("enable_count_t2", 64'(ens - e0), 64'd4);

    // Result FIFO full for 3 cycles in STORE; start during the push is ignored
    res_full = 1'b1;
    e0 = ens; u0 = pushes;
    load_a(tbl[1]);
    load_b(tbl[1]);
    exp_q.push_back(tbl[1].exp);
    pulse_start();
    n = 0;
    while ((ens - e0) < 4 && n < 200) begin cyc(); n++; end
    chk("reach_last_issue", 64'(ens - e0), 64'd4);
    cyc();                                   // WAIT -> STORE
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("res_data_hold", {48'd0, res_data}, {48'd0, tbl[1].exp});
    end
    chk("push_held_off", 64'(pushes - u0), 64'd0);
    res_full = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("push_on_release", 64'(pushes - u0), 64'd1);
    wait_done(10);
    cyc();
    chk("start_in_store_ignored", {63'd0, busy}, 64'd0);

    // Spurious done in IDLE/FETCH, start re-pulsed in WAIT
    e0 = ens; u0 = pushes;
    force_done = 1'b1; cyc(); force_done = 1'b0;
    pulse_start();
    force_done = 1'b1; cyc(); force_done = 1'b0;
    load_a(tbl[2]);
    load_b(tbl[2]);
    exp_q.push_back(tbl[2].exp);
    n = 0;
    while (!last_en && n < 200) begin cyc(); n++; end
    pulse_start();                           // lands in WAIT
    wait_done(200);
    chk("enable_count_t4", 64'(ens - e0), 64'd4);
    chk("push_count_t4", 64'(pushes - u0), 64'd1);
    repeat (2) cyc();
    chk("start_in_wait_ignored", {63'd0, busy}, 64'd0);
    run_vec(tbl[0]);

    // Asynchronous reset mid-WAIT
    e0 = ens; u0 = pushes;
    load_a(tbl[0]);
    load_b(tbl[0]);
    pulse_start();
    n = 0;
    while (!((ens - e0) >= 2 && last_en) && n < 200) begin cyc(); n++; end
    #2 rst = 1'b1;
    #1;
    chk("async_reset_outputs",
        {15'd0, a_pop, b_pop, enable, retro, res_push, busy, vec_done, A, B, res_data},
        64'd0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    prev_push = 1'b0;
    chk("no_push_after_abort", 64'(pushes - u0), 64'd0);
    run_vec(tbl[1]);

    // VEC_LEN = 1: A={9}, B={3}
    start1 = 1'b1;
    cyc();
    start1 = 1'b0;
    repeat (10) cyc();
    chk("push_count_len1", 64'(pushes1), 64'd1);
    chk("idle_len1", {63'd0, busy1}, 64'd0);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
